// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter
//   Arbitrates two frame sources (ch0 = UDP, ch1 = ICMP) onto a single
//   IP TX byte path. A request is granted from IDLE. The granted channel's
//   byte stream is then forwarded with one cycle of latency. After each
//   frame, or after a grant timeout, a fixed idle gap is inserted before
//   the next arbitration.
//
//   Build option: define IP_TX_ARB_RR_EN for round-robin tie breaking.
//   Otherwise ch0 wins ties (fixed priority).
//
// Parameters
//   P_GAP_CYCLES     idle cycles after each frame's last byte
//   P_GRANT_TIMEOUT  cycles a granted channel may wait before its first byte
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_chN_req / o_chN_grant       request / grant handshake, N = 0, 1
//   i_chN_type/_data/_len/_last/_valid   channel N frame stream
//   o_ip_type/_data/_len/_last/_valid    stream toward IP TX
//   o_busy                        arbiter not in IDLE
//   o_timeout_err                 one-cycle pulse on grant timeout
module ip_tx_arbiter #(
    parameter int unsigned P_GAP_CYCLES    = 12,
    parameter int unsigned P_GRANT_TIMEOUT = 2048
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ch0_req,
    output logic        o_ch0_grant,
    input  logic [7:0]  i_ch0_type,
    input  logic [7:0]  i_ch0_data,
    input  logic [15:0] i_ch0_len,
    input  logic        i_ch0_last,
    input  logic        i_ch0_valid,
    input  logic        i_ch1_req,
    output logic        o_ch1_grant,
    input  logic [7:0]  i_ch1_type,
    input  logic [7:0]  i_ch1_data,
    input  logic [15:0] i_ch1_len,
    input  logic        i_ch1_last,
    input  logic        i_ch1_valid,
    output logic [7:0]  o_ip_type,
    output logic [7:0]  o_ip_data,
    output logic [15:0] o_ip_len,
    output logic        o_ip_last,
    output logic        o_ip_valid,
    output logic        o_busy,
    output logic        o_timeout_err
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 16;
    localparam logic [31:0] GRANT_TO = 32'(P_GRANT_TIMEOUT);
    localparam logic [31:0] GAP_LEN  = 32'(P_GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_XFER  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [1:0]          grant_q, grant_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    logic [15:0]         gap_cnt_q, gap_cnt_d;
    logic                timeout_q, timeout_d;
    logic [DATA_W-1:0]   type_p1, type_d;
    logic [DATA_W-1:0]   data_p1, data_d;
    logic [LEN_W-1:0]    len_p1, len_d;
    logic                last_p1, last_d;
    logic                vld_p1, vld_d;

    // ---- stage p0: select the granted channel's inputs ----
    logic                req_p0, vld_p0, last_p0;
    logic [DATA_W-1:0]   type_p0, data_p0;
    logic [LEN_W-1:0]    len_p0;
    logic                winner;
    logic                any_req;
    logic                wait_expired, gap_expired;

    assign req_p0  = owner_q ? i_ch1_req   : i_ch0_req;
    assign vld_p0  = owner_q ? i_ch1_valid : i_ch0_valid;
    assign last_p0 = owner_q ? i_ch1_last  : i_ch0_last;
    assign type_p0 = owner_q ? i_ch1_type  : i_ch0_type;
    assign data_p0 = owner_q ? i_ch1_data  : i_ch0_data;
    assign len_p0  = owner_q ? i_ch1_len   : i_ch0_len;

    assign any_req      = i_ch0_req | i_ch1_req;
    assign wait_expired = ({16'd0, wait_cnt_q} + 32'd1) >= GRANT_TO;
    assign gap_expired  = ({16'd0, gap_cnt_q} + 32'd1) >= GAP_LEN;

`ifdef IP_TX_ARB_RR_EN
    logic last_win_q, last_win_d;
    // On a tie the channel that was not granted last time wins.
    assign winner = (i_ch0_req && i_ch1_req) ? ~last_win_q : i_ch1_req;
`else
    assign winner = ~i_ch0_req;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) state_d = S_GRANT;
            end
            S_GRANT: begin
                if (vld_p0)            state_d = last_p0 ? S_GAP : S_XFER;
                else if (!req_p0)      state_d = S_IDLE;
                else if (wait_expired) state_d = S_GAP;
            end
            S_XFER: begin
                if (vld_p0 && last_p0) state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_expired) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        grant_d    = grant_q;
        owner_d    = owner_q;
        timeout_d  = 1'b0;
        wait_cnt_d = 16'd0;
        gap_cnt_d  = 16'd0;
        vld_d      = 1'b0;
        last_d     = 1'b0;
        type_d     = type_p1;
        data_d     = data_p1;
        len_d      = len_p1;
`ifdef IP_TX_ARB_RR_EN
        last_win_d = last_win_q;
`endif
        // Any valid byte of the owner is forwarded in GRANT or XFER.
        if ((state_q == S_GRANT || state_q == S_XFER) && vld_p0) begin
            vld_d  = 1'b1;
            last_d = last_p0;
            type_d = type_p0;
            data_d = data_p0;
            len_d  = len_p0;
        end
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d = winner ? 2'b10 : 2'b01;
                    owner_d = winner;
`ifdef IP_TX_ARB_RR_EN
                    last_win_d = winner;
`endif
                end
            end
            S_GRANT: begin
                if (vld_p0) begin
                    if (last_p0) grant_d = 2'b00;
                end else if (!req_p0) begin
                    grant_d = 2'b00;
                end else if (wait_expired) begin
                    grant_d   = 2'b00;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = sat_inc(wait_cnt_q);
                end
            end
            S_XFER: begin
                // Grant drops on the same edge that launches o_ip_last.
                if (vld_p0 && last_p0) grant_d = 2'b00;
            end
            S_GAP: begin
                if (!gap_expired) gap_cnt_d = sat_inc(gap_cnt_q);
            end
            default: ;
        endcase
    end

    // ---- stage p1: registered outputs toward IP TX ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_q    <= 2'b00;
            owner_q    <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= 16'd0;
            gap_cnt_q  <= 16'd0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            type_p1    <= '0;
            data_p1    <= '0;
            len_p1     <= '0;
        end else begin
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            vld_p1     <= vld_d;
            last_p1    <= last_d;
            type_p1    <= type_d;
            data_p1    <= data_d;
            len_p1     <= len_d;
        end
    end

`ifdef IP_TX_ARB_RR_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_win_q <= 1'b1;
        end else begin
            last_win_q <= last_win_d;
        end
    end
`endif

    assign o_ch0_grant   = grant_q[0];
    assign o_ch1_grant   = grant_q[1];
    assign o_ip_type     = type_p1;
    assign o_ip_data     = data_p1;
    assign o_ip_len      = len_p1;
    assign o_ip_last     = last_p1;
    assign o_ip_valid    = vld_p1;
    assign o_busy        = (state_q != S_IDLE);
    assign o_timeout_err = timeout_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
module tb_ip_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, v0, v1, l0, l1;
    logic [7:0]  d0, d1, t0, t1;
    logic [15:0] n0, n1;
    logic        g0, g1;
    logic [7:0]  o_type, o_data;
    logic [15:0] o_len;
    logic        o_last, o_valid, o_busy, o_to;

    int n_cmp = 0;
    int n_err = 0;

    ip_tx_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_ch0_req(req0), .o_ch0_grant(g0), .i_ch0_type(t0), .i_ch0_data(d0),
        .i_ch0_len(n0), .i_ch0_last(l0), .i_ch0_valid(v0),
        .i_ch1_req(req1), .o_ch1_grant(g1), .i_ch1_type(t1), .i_ch1_data(d1),
        .i_ch1_len(n1), .i_ch1_last(l1), .i_ch1_valid(v1),
        .o_ip_type(o_type), .o_ip_data(o_data), .o_ip_len(o_len),
        .o_ip_last(o_last), .o_ip_valid(o_valid), .o_busy(o_busy),
        .o_timeout_err(o_to)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pre_idle;
        logic        req0, req1, v0, l0, v1, l1;
        logic [7:0]  d0, d1, typ;
        logic [15:0] len;
        logic [1:0]  e_grant;
        logic        e_vld, e_last;
        logic [7:0]  e_data;
        logic        e_busy;
        logic [7:0]  e_type;
        logic [15:0] e_len;
        logic        chk_tl;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; v0 = 0; v1 = 0; l0 = 0; l1 = 0;
        d0 = 0; d1 = 0; t0 = 0; t1 = 0; n0 = 0; n1 = 0;
    endtask

    task automatic wait_idle();
        int k;
        clear_inputs();
        k = 0;
        while (o_busy && k < 100) begin
            tick();
            k++;
        end
        check("wait_idle", {63'd0, o_busy}, 64'd0);
    endtask

    task automatic set_ch(input int ch, input logic v, input logic l,
                          input logic [7:0] d, input logic [7:0] t, input logic [15:0] n);
        if (ch == 0) begin v0 = v; l0 = l; d0 = d; t0 = t; n0 = n; end
        else         begin v1 = v; l1 = l; d1 = d; t1 = t; n1 = n; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n_hi, g, exp_g, lasts;
        int rem [2];
        clear_inputs();

        //                pi r0 r1 v0 l0 v1 l1 d0     d1     typ  len    eg     ev el ed     eb et   elen  ct
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0, 16'd0,2'b00,1'b0,1'b0,8'h00,1'b0,8'd0, 16'd0,1'b1};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0, 16'd0,2'b01,1'b0,1'b0,8'h00,1'b1,8'd0, 16'd0,1'b1};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'hA1,8'h00,8'd17,16'd3,2'b01,1'b1,1'b0,8'hA1,1'b1,8'd17,16'd3,1'b1};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'hA2,8'h00,8'd17,16'd3,2'b01,1'b1,1'b0,8'hA2,1'b1,8'd17,16'd3,1'b1};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,8'hA3,8'h00,8'd17,16'd3,2'b00,1'b1,1'b1,8'hA3,1'b1,8'd17,16'd3,1'b1};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0, 16'd0,2'b00,1'b0,1'b0,8'h00,1'b1,8'd17,16'd3,1'b1};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0, 16'd0,2'b10,1'b0,1'b0,8'h00,1'b1,8'd0, 16'd0,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0, 16'd0,2'b00,1'b0,1'b0,8'h00,1'b0,8'd0, 16'd0,1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0, 16'd0,2'b01,1'b0,1'b0,8'h00,1'b1,8'd0, 16'd0,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h00,8'h5A,8'd1, 16'd8,2'b00,1'b0,1'b0,8'h00,1'b0,8'd17,16'd3,1'b1};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd1, 16'd8,2'b10,1'b0,1'b0,8'h00,1'b1,8'd17,16'd3,1'b1};
        tbl[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h00,8'h5A,8'd1, 16'd8,2'b00,1'b1,1'b1,8'h5A,1'b1,8'd1, 16'd8,1'b1};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0, 16'd0,2'b00,1'b0,1'b0,8'h00,1'b1,8'd1, 16'd8,1'b1};

        rst = 1'b1;
        tick();
        tick();
        check("rst_outputs", {o_type, o_data, o_len, o_last, o_valid, o_busy, o_to, g0, g1}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].pre_idle) wait_idle();
            req0 = tbl[i].req0; req1 = tbl[i].req1;
            v0 = tbl[i].v0; l0 = tbl[i].l0; d0 = tbl[i].d0;
            v1 = tbl[i].v1; l1 = tbl[i].l1; d1 = tbl[i].d1;
            t0 = tbl[i].typ; t1 = tbl[i].typ; n0 = tbl[i].len; n1 = tbl[i].len;
            tick();
            check($sformatf("v%0d_grant", i), {62'd0, g1, g0}, {62'd0, tbl[i].e_grant});
            check($sformatf("v%0d_vld_last", i), {62'd0, o_valid, o_last},
                  {62'd0, tbl[i].e_vld, tbl[i].e_last});
            check($sformatf("v%0d_busy", i), {63'd0, o_busy}, {63'd0, tbl[i].e_busy});
            check($sformatf("v%0d_timeout", i), {63'd0, o_to}, 64'd0);
            if (tbl[i].e_vld)
                check($sformatf("v%0d_data", i), {56'd0, o_data}, {56'd0, tbl[i].e_data});
            if (tbl[i].chk_tl)
                check($sformatf("v%0d_type_len", i), {40'd0, o_type, o_len},
                      {40'd0, tbl[i].e_type, tbl[i].e_len});
        end

        // 20-byte ch0 frame, len 28, type 17, then the idle gap
        wait_idle();
        req0 = 1;
        tick();
        check("f20_grant", {62'd0, g1, g0}, 64'd1);
        for (int i = 0; i < 20; i++) begin
            set_ch(0, 1'b1, (i == 19), 8'(i + 1), 8'd17, 16'd28);
            tick();
            check($sformatf("f20_b%0d", i), {54'd0, o_valid, o_last, o_data},
                  {54'd0, 1'b1, (i == 19), 8'(i + 1)});
        end
        check("f20_end", {38'd0, g0, o_type, o_len, 1'b0}, {38'd0, 1'b0, 8'd17, 16'd28, 1'b0});
        clear_inputs();
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (o_valid || o_last) k++;
            if (c < 12) check($sformatf("gap_busy%0d", c), {63'd0, o_busy}, 64'd1);
        end
        check("gap_done", {63'd0, o_busy}, 64'd0);
        check("gap_quiet", 64'(k), 64'd0);

        // ch1 request during a ch0 frame waits for the gap
        req0 = 1;
        tick();
        check("mid_grant0", {62'd0, g1, g0}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            set_ch(0, 1'b1, (i == 5), 8'h30 + 8'(i), 8'd17, 16'd6);
            if (i == 2) req1 = 1;
            tick();
            check($sformatf("mid_b%0d", i), {61'd0, g1, g0, o_valid},
                  {61'd0, 1'b0, (i != 5), 1'b1});
        end
        req0 = 0; set_ch(0, 1'b0, 1'b0, 8'h00, 8'd0, 16'd0);
        k = 0;
        while (!g1 && k < 40) begin
            tick();
            k++;
        end
        check("mid_ch1_latency", 64'(k), 64'd13);
        set_ch(1, 1'b1, 1'b1, 8'hC3, 8'd1, 16'd1);
        tick();
        check("mid_ch1_byte", {54'd0, o_valid, o_last, o_data}, {54'd0, 1'b1, 1'b1, 8'hC3});
        wait_idle();

        // both channels, three back-to-back 2-byte frames each
        rem[0] = 3; rem[1] = 3;
        req0 = 1; req1 = 1;
        for (int f = 0; f < 6; f++) begin
            tick();
            k = 0;
            while (!g0 && !g1 && k < 100) begin
                tick();
                k++;
            end
            g = g1 ? 1 : 0;
`ifdef IP_TX_ARB_RR_EN
            exp_g = f % 2;
`else
            exp_g = (f >= 3) ? 1 : 0;
`endif
            check($sformatf("order_f%0d", f), {62'd0, g1, g0},
                  (exp_g == 1) ? 64'd2 : 64'd1);
            if (!g0 && !g1) break;
            set_ch(g, 1'b1, 1'b0, 8'h10, 8'd17, 16'd2);
            tick();
            set_ch(g, 1'b1, 1'b1, 8'h11, 8'd17, 16'd2);
            tick();
            set_ch(g, 1'b0, 1'b0, 8'h00, 8'd0, 16'd0);
            rem[g] = rem[g] - 1;
            if (g == 0) req0 = (rem[0] > 0);
            else        req1 = (rem[1] > 0);
        end
        wait_idle();

        // grant timeout with ch1 pending
        req0 = 1;
        tick();
        check("to_grant", {62'd0, g1, g0}, 64'd1);
        req1 = 1;
        n_hi = 1;
        k = 0;
        while (k < 3000) begin
            tick();
            k++;
            if (g0) n_hi++;
            else break;
        end
        check("to_grant_cycles", 64'(n_hi), 64'd2048);
        check("to_pulse", {62'd0, o_to, g0}, 64'd2);
        req0 = 0;
        tick();
        check("to_pulse_end", {63'd0, o_to}, 64'd0);
        k = 1;
        while (!g1 && k < 40) begin
            tick();
            k++;
        end
        check("to_ch1_latency", 64'(k), 64'd13);
        set_ch(1, 1'b1, 1'b1, 8'h77, 8'd1, 16'd1);
        tick();
        check("to_ch1_byte", {54'd0, o_valid, o_last, o_data}, {54'd0, 1'b1, 1'b1, 8'h77});
        wait_idle();

        // reset in the middle of a 40-byte frame
        req0 = 1;
        tick();
        check("rstf_grant", {62'd0, g1, g0}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            set_ch(0, 1'b1, 1'b0, 8'h50 + 8'(i), 8'd17, 16'd40);
            tick();
        end
        check("rstf_fwd", {55'd0, o_valid, o_data}, {55'd0, 1'b1, 8'h54});
        set_ch(0, 1'b1, 1'b0, 8'h55, 8'd17, 16'd40);
        #2;
        rst = 1'b1;
        #1;
        check("rstf_outputs", {o_type, o_data, o_len, o_last, o_valid, o_busy, o_to, g0, g1}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        req0 = 0;
        lasts = 0;
        for (int i = 6; i < 40; i++) begin
            set_ch(0, 1'b1, (i == 39), 8'h50 + 8'(i), 8'd17, 16'd40);
            tick();
            if (o_last || o_valid || o_busy) lasts++;
        end
        set_ch(0, 1'b0, 1'b0, 8'h00, 8'd0, 16'd0);
        check("rstf_no_output", 64'(lasts), 64'd0);
        req0 = 1;
        tick();
        check("rstf_regrant", {62'd0, g1, g0}, 64'd1);
        set_ch(0, 1'b1, 1'b1, 8'hEE, 8'd17, 16'd1);
        tick();
        check("rstf_new_frame", {54'd0, o_valid, o_last, o_data}, {54'd0, 1'b1, 1'b1, 8'hEE});
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
